// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - raster position tracker flagging completed KxK convolution windows
module conv_window_ctrl #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int OW     = (IMG_W - K) / STRIDE + 1,
  parameter int OH     = (IMG_H - K) / STRIDE + 1,
  parameter int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  parameter int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iValid,
  input  logic          iSOF,
  output logic          oValid,
  output logic [CW-1:0] oWinCol,
  output logic [RW-1:0] oWinRow,
  output logic          oLastWin,
  output logic          oFrameDone,
  output logic          oSofErr
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
  localparam logic [CW-1:0] COL_STR1 = CW'(STRIDE - 1);
  localparam logic [CW-1:0] OW_LAST  = CW'(OW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);
  localparam logic [RW-1:0] ROW_STR1 = RW'(STRIDE - 1);
  localparam logic [RW-1:0] OH_LAST  = RW'(OH - 1);

  // Registered raster position, stride phase and window index counters
  logic [CW-1:0] col, cph, wcol;
  logic [RW-1:0] row, rph, wrow;

  // Position of the pixel being presented (SOF forces everything to origin)
  logic [CW-1:0] eff_col, eff_cph, eff_wcol;
  logic [RW-1:0] eff_row, eff_rph, eff_wrow;
  logic          col_start, col_hit, col_end;
  logic          row_start, row_hit, row_end;
  logic          win_hit;

  logic [CW-1:0] nxt_col, nxt_cph, nxt_wcol;
  logic [RW-1:0] nxt_row, nxt_rph, nxt_wrow;

  // Resolve the current pixel's position and whether it closes a window
  always_comb begin
    eff_col   = iSOF ? '0 : col;
    eff_cph   = iSOF ? '0 : cph;
    eff_wcol  = iSOF ? '0 : wcol;
    eff_row   = iSOF ? '0 : row;
    eff_rph   = iSOF ? '0 : rph;
    eff_wrow  = iSOF ? '0 : wrow;
    col_start = (eff_col >= COL_K1);
    row_start = (eff_row >= ROW_K1);
    col_hit   = col_start && (eff_cph == '0) && (eff_wcol <= OW_LAST);
    row_hit   = row_start && (eff_rph == '0) && (eff_wrow <= OH_LAST);
    col_end   = (eff_col == COL_LAST);
    row_end   = (eff_row == ROW_LAST);
    win_hit   = col_hit && row_hit;
  end

  // Next-state for the position, phase and window counters after this pixel
  always_comb begin
    nxt_col  = eff_col + 1'b1;
    nxt_cph  = eff_cph;
    nxt_wcol = eff_wcol;
    nxt_row  = eff_row;
    nxt_rph  = eff_rph;
    nxt_wrow = eff_wrow;
    if (col_start) begin
      nxt_cph = (eff_cph == COL_STR1) ? '0 : eff_cph + 1'b1;
      if (col_hit) nxt_wcol = eff_wcol + 1'b1;
    end
    if (col_end) begin
      nxt_col  = '0;
      nxt_cph  = '0;
      nxt_wcol = '0;
      if (row_end) begin
        nxt_row  = '0;
        nxt_rph  = '0;
        nxt_wrow = '0;
      end else begin
        nxt_row = eff_row + 1'b1;
        if (row_start) begin
          nxt_rph = (eff_rph == ROW_STR1) ? '0 : eff_rph + 1'b1;
          if (row_hit) nxt_wrow = eff_wrow + 1'b1;
        end
      end
    end
  end

  // Counters advance only on accepted pixels; idle cycles hold state
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      col  <= '0;
      cph  <= '0;
      wcol <= '0;
      row  <= '0;
      rph  <= '0;
      wrow <= '0;
    end else if (iValid) begin
      col  <= nxt_col;
      cph  <= nxt_cph;
      wcol <= nxt_wcol;
      row  <= nxt_row;
      rph  <= nxt_rph;
      wrow <= nxt_wrow;
    end
  end

  // One-cycle status pulses; window coordinates hold between hits
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oValid     <= 1'b0;
      oWinCol    <= '0;
      oWinRow    <= '0;
      oLastWin   <= 1'b0;
      oFrameDone <= 1'b0;
      oSofErr    <= 1'b0;
    end else begin
      oValid     <= iValid && win_hit;
      oLastWin   <= iValid && win_hit && (eff_wcol == OW_LAST) && (eff_wrow == OH_LAST);
      oFrameDone <= iValid && col_end && row_end;
      oSofErr    <= iValid && iSOF && ((col != '0) || (row != '0));
      if (iValid && win_hit) begin
        oWinCol <= eff_wcol;
        oWinRow <= eff_wrow;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb/tb_conv_window_ctrl.sv - directed bench for conv_window_ctrl across several geometries
module tb_conv_window_ctrl;

  logic iCLK = 1'b0;
  logic iRSTn = 1'b0;
  always #5 iCLK = ~iCLK;

  int   sel = 0;
  logic v = 1'b0;
  logic s = 1'b0;
  int   total = 0;
  int   bad = 0;

  // a: 8x8 K3 S2, b: 9x9 K3 S3, c: 8x8 K3 S1, d: 4x4 K3 S1
  logic a_v, a_s, a_ov, a_lw, a_fd, a_se;
  logic [2:0] a_wc, a_wr;
  logic b_v, b_s, b_ov, b_lw, b_fd, b_se;
  logic [3:0] b_wc, b_wr;
  logic c_v, c_s, c_ov, c_lw, c_fd, c_se;
  logic [2:0] c_wc, c_wr;
  logic d_v, d_s, d_ov, d_lw, d_fd, d_se;
  logic [1:0] d_wc, d_wr;

  assign a_v = (sel == 0) && v;  assign a_s = (sel == 0) && s;
  assign b_v = (sel == 1) && v;  assign b_s = (sel == 1) && s;
  assign c_v = (sel == 2) && v;  assign c_s = (sel == 2) && s;
  assign d_v = (sel == 3) && v;  assign d_s = (sel == 3) && s;

  conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2)) u_a (
    .iCLK(iCLK), .iRSTn(iRSTn), .iValid(a_v), .iSOF(a_s), .oValid(a_ov), .oWinCol(a_wc),
    .oWinRow(a_wr), .oLastWin(a_lw), .oFrameDone(a_fd), .oSofErr(a_se));
  conv_window_ctrl #(.IMG_W(9), .IMG_H(9), .K(3), .STRIDE(3)) u_b (
    .iCLK(iCLK), .iRSTn(iRSTn), .iValid(b_v), .iSOF(b_s), .oValid(b_ov), .oWinCol(b_wc),
    .oWinRow(b_wr), .oLastWin(b_lw), .oFrameDone(b_fd), .oSofErr(b_se));
  conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(1)) u_c (
    .iCLK(iCLK), .iRSTn(iRSTn), .iValid(c_v), .iSOF(c_s), .oValid(c_ov), .oWinCol(c_wc),
    .oWinRow(c_wr), .oLastWin(c_lw), .oFrameDone(c_fd), .oSofErr(c_se));
  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)) u_d (
    .iCLK(iCLK), .iRSTn(iRSTn), .iValid(d_v), .iSOF(d_s), .oValid(d_ov), .oWinCol(d_wc),
    .oWinRow(d_wr), .oLastWin(d_lw), .oFrameDone(d_fd), .oSofErr(d_se));

  int m_ov, m_wc, m_wr, m_lw, m_fd, m_se;

  // Route the selected instance's outputs to common observation signals
  always_comb begin
    m_ov = 0; m_wc = 0; m_wr = 0; m_lw = 0; m_fd = 0; m_se = 0;
    case (sel)
      0: begin m_ov = int'(a_ov); m_wc = int'(a_wc); m_wr = int'(a_wr); m_lw = int'(a_lw); m_fd = int'(a_fd); m_se = int'(a_se); end
      1: begin m_ov = int'(b_ov); m_wc = int'(b_wc); m_wr = int'(b_wr); m_lw = int'(b_lw); m_fd = int'(b_fd); m_se = int'(b_se); end
      2: begin m_ov = int'(c_ov); m_wc = int'(c_wc); m_wr = int'(c_wr); m_lw = int'(c_lw); m_fd = int'(c_fd); m_se = int'(c_se); end
      default: begin m_ov = int'(d_ov); m_wc = int'(d_wc); m_wr = int'(d_wr); m_lw = int'(d_lw); m_fd = int'(d_fd); m_se = int'(d_se); end
    endcase
  end

  typedef struct {
    int idx;
    int wc;
    int wr;
    int last;
  } win_t;

  win_t expq[$];
  int   fd_q[$];
  int   se_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int in_q(input int q[$], input int p);
    foreach (q[i]) if (q[i] == p) return 1;
    return 0;
  endfunction

  task automatic addw(input int idx, input int wc, input int wr, input int last);
    win_t w;
    w.idx = idx; w.wc = wc; w.wr = wr; w.last = last;
    expq.push_back(w);
  endtask

  // One cycle: present a pixel (or idle when val=0), then check the registered result
  task automatic pix(input bit val, input bit sof, input int p);
    int exp_v;
    v = val; s = sof;
    @(posedge iCLK);
    #1;
    v = 1'b0; s = 1'b0;
    exp_v = (val && expq.size() > 0 && expq[0].idx == p) ? 1 : 0;
    chk($sformatf("valid@%0d", p), m_ov, exp_v);
    if (exp_v == 1) begin
      chk($sformatf("wcol@%0d", p), m_wc, expq[0].wc);
      chk($sformatf("wrow@%0d", p), m_wr, expq[0].wr);
      chk($sformatf("last@%0d", p), m_lw, expq[0].last);
      void'(expq.pop_front());
    end else begin
      chk($sformatf("last@%0d", p), m_lw, 0);
    end
    chk($sformatf("fdone@%0d", p), m_fd, (val && in_q(fd_q, p)) ? 1 : 0);
    chk($sformatf("soferr@%0d", p), m_se, (val && in_q(se_q, p)) ? 1 : 0);
  endtask

  task automatic run(input int first, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      pix(1'b1, 1'b0, first + i);
      if (toggle) pix(1'b0, 1'b0, -1);
    end
  endtask

  task automatic load_s2_frame();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        addw(8 * (2 + 2 * r) + 2 + 2 * c, c, r, (r == 2 && c == 2) ? 1 : 0);
    fd_q.push_back(63);
  endtask

  task automatic finish_case(input string name);
    chk({name, "_pulses_left"}, expq.size(), 0);
    expq.delete();
    fd_q.delete();
    se_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_valid", int'(a_ov), 0);
    chk("rst_wcol", int'(a_wc), 0);
    chk("rst_wrow", int'(a_wr), 0);
    chk("rst_last", int'(a_lw), 0);
    chk("rst_fdone", int'(a_fd), 0);
    chk("rst_soferr", int'(a_se), 0);
    iRSTn = 1'b1;

    sel = 0;
    load_s2_frame();
    run(0, 64, 1'b0);
    finish_case("s2_contig");

    load_s2_frame();
    run(0, 64, 1'b1);
    finish_case("s2_toggle");

    sel = 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        addw(9 * (2 + 3 * r) + 2 + 3 * c, c, r, (r == 2 && c == 2) ? 1 : 0);
    fd_q.push_back(80);
    run(0, 81, 1'b0);
    finish_case("s3_9x9");

    sel = 2;
    addw(18, 0, 0, 0);
    addw(19, 1, 0, 0);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        addw(20 + 8 * (r + 2) + c + 2, c, r, (r == 5 && c == 5) ? 1 : 0);
    fd_q.push_back(83);
    se_q.push_back(20);
    run(0, 20, 1'b0);
    pix(1'b1, 1'b1, 20);
    run(21, 63, 1'b0);
    finish_case("sof_resync");

    sel = 3;
    for (int f = 0; f < 2; f++) begin
      addw(16 * f + 10, 0, 0, 0);
      addw(16 * f + 11, 1, 0, 0);
      addw(16 * f + 14, 0, 1, 0);
      addw(16 * f + 15, 1, 1, 1);
      fd_q.push_back(16 * f + 15);
    end
    run(0, 32, 1'b0);
    finish_case("b2b_4x4");

    sel = 0;
    addw(18, 0, 0, 0);
    addw(20, 1, 0, 0);
    addw(22, 2, 0, 0);
    run(0, 30, 1'b0);
    chk("hold_wcol", m_wc, 2);
    chk("hold_wrow", m_wr, 0);
    finish_case("pre_reset");
    #1 iRSTn = 1'b0;
    #1;
    chk("async_valid", m_ov, 0);
    chk("async_wcol", m_wc, 0);
    chk("async_last", m_lw, 0);
    chk("async_fdone", m_fd, 0);
    @(posedge iCLK);
    #2 iRSTn = 1'b1;
    load_s2_frame();
    run(0, 64, 1'b0);
    finish_case("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
